mem_stage_mc: RTL and testbench

- Parametrised successor of the LAPIDO memory stage.
- Supports byte/halfword/word loads and stores with byte enables and sign/zero extension.
- Configurable memory latency, with a busy/stall handshake back to EX/ID.
- Sits between EX and WB; registers all WB-bound fields exactly as the single-cycle stage did.

---
 rtl/mem_stage_mc_pkg.sv | 13 +
 rtl/mem_stage_mc_data_mem_be.sv | 22 ++
 rtl/mem_stage_mc.sv | 107 ++++++++++
 tb/tb_mem_stage_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_mc_pkg.sv
// mem_stage_mc_pkg: access-size codes, FSM encodings and byte-enable helper shared by the memory stage.
package mem_stage_mc_pkg;
   localparam logic [1:0] MEM_SZ_B = 2'd0;
   localparam logic [1:0] MEM_SZ_H = 2'd1;
   localparam logic [1:0] MEM_SZ_W = 2'd2;
   localparam logic [0:0] MEMST_IDLE = 1'b0;
   localparam logic [0:0] MEMST_WAIT = 1'b1;
   localparam int PC_WIDTH = 32;
   function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
      return size == MEM_SZ_B ? 4'b0001 << off :
             size == MEM_SZ_H ? (off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction
endpackage

// File: rtl/mem_stage_mc_data_mem_be.sv
// data_mem_be: byte-enabled memory, synchronous write, combinational read, cleared on reset.
module data_mem_be #(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       write_data,
   input  logic [3:0]        byte_en,
   output logic [31:0]       read_data
);
   logic [31:0] r_mem [2**ADDR_W];
   assign read_data = r_mem[addr];
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
      end else begin
         for (int b = 0; b < 4; b++)
            if (byte_en[b]) r_mem[addr][8*b +: 8] <= write_data[8*b +: 8];
      end
   end
endmodule

// File: rtl/mem_stage_mc.sv
// mem_stage_mc: EX->WB memory stage with byte/half/word access, MEM_LAT wait states and busy stall.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of masking the low address bits.
module mem_stage_mc
   import mem_stage_mc_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 10,
   parameter int MEM_LAT = 0,
   parameter int PC_W    = PC_WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [1:0]        mem_size,
   input  logic              mem_unsigned,
   input  logic [1:0]        wb_res_mux,
   input  logic              reg_write_enable,
   input  logic [PC_W-1:0]   in_next_pc,
   input  logic [DATA_W-1:0] alu_res,
   input  logic [DATA_W-1:0] in_mem_addr,
   input  logic [DATA_W-1:0] in_mem_data,
   input  logic [DATA_W-1:0] in_immediate,
   input  logic [4:0]        in_reg_dst,
   output logic              mem_busy,
   output logic              out_valid,
   output logic [1:0]        out_wb_res_mux,
   output logic              out_reg_write_enable,
   output logic [PC_W-1:0]   out_next_pc,
   output logic [DATA_W-1:0] out_alu_res,
   output logic [DATA_W-1:0] out_imm,
   output logic [4:0]        out_reg_dst,
   output logic [DATA_W-1:0] out_mem_data,
   output logic              out_misalign
);
   logic [0:0]        r_state;
   logic [3:0]        r_cnt;
   logic              w_start, w_hold, w_mis, w_trap;
   logic [1:0]        w_off;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wdata, w_rdata, w_lane, w_ext, w_ld;
   logic              w_unused;
   assign w_start  = (MEM_LAT != 0) && r_state == MEMST_IDLE && in_valid && (mem_read || mem_write);
   assign w_hold   = r_state == MEMST_WAIT && r_cnt != 4'd0;
   assign mem_busy = w_start || w_hold;
   assign w_mis = (mem_read || mem_write) &&
                  ((mem_size == MEM_SZ_H && in_mem_addr[0]) ||
                   (mem_size != MEM_SZ_B && mem_size != MEM_SZ_H && in_mem_addr[1:0] != 2'b00));
`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap = w_mis;
`else
   assign w_trap = 1'b0;
`endif
   // Without the trap, the low bits are simply forced to the natural alignment.
   assign w_off = mem_size == MEM_SZ_B ? in_mem_addr[1:0] :
                  mem_size == MEM_SZ_H ? {in_mem_addr[1], 1'b0} : 2'b00;
   assign w_be = (!w_start && !w_hold && in_valid && mem_write && !w_trap) ? be_of(mem_size, w_off) : 4'b0000;
   assign w_wdata = mem_size == MEM_SZ_B ? {4{in_mem_data[7:0]}} :
                    mem_size == MEM_SZ_H ? {2{in_mem_data[15:0]}} : in_mem_data;
   assign w_lane = w_rdata >> {w_off, 3'b000};
   assign w_ext = mem_size == MEM_SZ_B ? {{24{~mem_unsigned & w_lane[7]}}, w_lane[7:0]} :
                  mem_size == MEM_SZ_H ? {{16{~mem_unsigned & w_lane[15]}}, w_lane[15:0]} : w_rdata;
   assign w_ld = (mem_read && !mem_write && !w_trap) ? w_ext : '0;
   assign w_unused = ^{in_mem_addr[DATA_W-1:ADDR_W+2], w_lane[DATA_W-1:16], w_mis};
   data_mem_be #(.ADDR_W(ADDR_W)) u_mem (
      .clk        (clk),
      .rst        (rst),
      .addr       (in_mem_addr[ADDR_W+1:2]),
      .write_data (w_wdata),
      .byte_en    (w_be),
      .read_data  (w_rdata)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state              <= MEMST_IDLE;
         r_cnt                <= 4'd0;
         out_valid            <= 1'b0;
         out_wb_res_mux       <= '0;
         out_reg_write_enable <= 1'b0;
         out_next_pc          <= '0;
         out_alu_res          <= '0;
         out_imm              <= '0;
         out_reg_dst          <= '0;
         out_mem_data         <= '0;
         out_misalign         <= 1'b0;
      end else if (w_start) begin
         r_state   <= MEMST_WAIT;
         r_cnt     <= 4'(MEM_LAT - 1);
         out_valid <= 1'b0;
      end else if (w_hold) begin
         r_cnt     <= r_cnt - 4'd1;
         out_valid <= 1'b0;
      end else begin
         r_state              <= MEMST_IDLE;
         out_valid            <= in_valid;
         out_wb_res_mux       <= wb_res_mux;
         out_reg_write_enable <= reg_write_enable && !w_trap;
         out_next_pc          <= in_next_pc;
         out_alu_res          <= alu_res;
         out_imm              <= in_immediate;
         out_reg_dst          <= in_reg_dst;
         out_mem_data         <= w_ld;
         out_misalign         <= w_trap;
      end
   end
endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc: drives a MEM_LAT=0 and a MEM_LAT=3 stage with identical ops, checked against a byte-array model.
module tb_mem_stage_mc;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst, in_valid, mem_read, mem_write, mem_unsigned, reg_write_enable;
   logic [1:0] mem_size, wb_res_mux;
   logic [31:0] in_next_pc, alu_res, in_mem_addr, in_mem_data, in_immediate;
   logic [4:0] in_reg_dst;
   logic [1:0] busy, ov, owe, omis;
   logic [1:0][1:0] owbm;
   logic [1:0][31:0] opc, oalu, oimm, omd;
   logic [1:0][4:0] ord;
   int n_cmp = 0, n_bad = 0;
   logic [7:0] mem_b [4096];
   typedef struct {
      logic v; logic [1:0] wbm; logic rwe; logic [31:0] pc, alu, imm, md; logic [4:0] rd; logic mis;
   } exp_t;

   mem_stage_mc #(.MEM_LAT(0)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .wb_res_mux(wb_res_mux),
      .reg_write_enable(reg_write_enable), .in_next_pc(in_next_pc), .alu_res(alu_res),
      .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data), .in_immediate(in_immediate),
      .in_reg_dst(in_reg_dst), .mem_busy(busy[0]), .out_valid(ov[0]), .out_wb_res_mux(owbm[0]),
      .out_reg_write_enable(owe[0]), .out_next_pc(opc[0]), .out_alu_res(oalu[0]), .out_imm(oimm[0]),
      .out_reg_dst(ord[0]), .out_mem_data(omd[0]), .out_misalign(omis[0]));
   mem_stage_mc #(.MEM_LAT(3)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_unsigned(mem_unsigned), .wb_res_mux(wb_res_mux),
      .reg_write_enable(reg_write_enable), .in_next_pc(in_next_pc), .alu_res(alu_res),
      .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data), .in_immediate(in_immediate),
      .in_reg_dst(in_reg_dst), .mem_busy(busy[1]), .out_valid(ov[1]), .out_wb_res_mux(owbm[1]),
      .out_reg_write_enable(owe[1]), .out_next_pc(opc[1]), .out_alu_res(oalu[1]), .out_imm(oimm[1]),
      .out_reg_dst(ord[1]), .out_mem_data(omd[1]), .out_misalign(omis[1]));

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_outs(int u, exp_t e);
      string p;
      p = u != 0 ? "lat3" : "lat0";
      chk({p, " valid"}, 32'(ov[u]), 32'(e.v));
      chk({p, " wbm"}, 32'(owbm[u]), 32'(e.wbm));
      chk({p, " rwe"}, 32'(owe[u]), 32'(e.rwe));
      chk({p, " pc"}, opc[u], e.pc);
      chk({p, " alu"}, oalu[u], e.alu);
      chk({p, " imm"}, oimm[u], e.imm);
      chk({p, " rd"}, 32'(ord[u]), 32'(e.rd));
      chk({p, " mdata"}, omd[u], e.md);
      chk({p, " misalign"}, 32'(omis[u]), 32'(e.mis));
   endtask

   // Reference: little-endian byte array, 4 KiB image, byte address wraps at 12 bits.
   task automatic model(output exp_t e);
      int nb, a;
      logic mis, trap;
      logic [31:0] v;
      nb = mem_size == 2'd0 ? 1 : mem_size == 2'd1 ? 2 : 4;
      a = int'(in_mem_addr[11:0]);
      mis = (mem_read || mem_write) && (a % nb != 0);
`ifdef MEM_MISALIGN_TRAP_EN
      trap = mis;
`else
      trap = 1'b0;
`endif
      a = a - (a % nb);
      e.v = 1'b1; e.wbm = wb_res_mux; e.rwe = reg_write_enable && !trap; e.pc = in_next_pc;
      e.alu = alu_res; e.imm = in_immediate; e.rd = in_reg_dst; e.mis = trap; e.md = 32'd0;
      if (mem_write && !trap)
         for (int i = 0; i < nb; i++) mem_b[a + i] = in_mem_data[8*i +: 8];
      if (mem_read && !mem_write && !trap) begin
         v = 32'd0;
         for (int i = 0; i < nb; i++) v = v + (32'(mem_b[a + i]) << (8 * i));
         if (!mem_unsigned && nb < 4 && v[8*nb-1]) v = v - (32'd1 << (8 * nb));
         e.md = v;
      end
   endtask

   task automatic op(bit rd, bit wr, logic [1:0] sz, bit uns, logic [31:0] addr, logic [31:0] data);
      exp_t e;
      bit m;
      @(negedge clk);
      in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
      in_mem_addr = addr; in_mem_data = data; wb_res_mux = 2'($urandom);
      reg_write_enable = 1'($urandom); in_next_pc = $urandom; alu_res = $urandom;
      in_immediate = $urandom; in_reg_dst = 5'($urandom);
      model(e);
      m = rd || wr;
      #1;
      chk("lat0 busy", 32'(busy[0]), 32'd0);
      chk("lat3 busy accept", 32'(busy[1]), 32'(m));
      @(posedge clk); #1;
      chk_outs(0, e);
      if (m) begin
         for (int k = 1; k <= 3; k++) begin
            chk("lat3 bubble", 32'(ov[1]), 32'd0);
            chk("lat3 busy wait", 32'(busy[1]), 32'(k < 3));
            @(posedge clk); #1;
            chk_outs(0, e);
         end
      end
      chk_outs(1, e);
   endtask

   task automatic idle_cycle();
      logic [31:0] a;
      @(negedge clk);
      a = $urandom;
      in_valid = 1'b0; mem_write = 1'($urandom); mem_read = 1'($urandom);
      in_mem_addr = $urandom_range(0, 63); in_mem_data = $urandom; alu_res = a;
      #1;
      chk("idle busy0", 32'(busy[0]), 32'd0);
      chk("idle busy3", 32'(busy[1]), 32'd0);
      @(posedge clk); #1;
      for (int u = 0; u < 2; u++) begin
         chk("idle valid", 32'(ov[u]), 32'd0);
         chk("idle alu", oalu[u], a);
      end
   endtask

   task automatic chk_zero(string tag);
      for (int u = 0; u < 2; u++) begin
         chk({tag, " valid"}, 32'(ov[u]), 32'd0);
         chk({tag, " wbm"}, 32'(owbm[u]), 32'd0);
         chk({tag, " rwe"}, 32'(owe[u]), 32'd0);
         chk({tag, " pc"}, opc[u], 32'd0);
         chk({tag, " alu"}, oalu[u], 32'd0);
         chk({tag, " imm"}, oimm[u], 32'd0);
         chk({tag, " rd"}, 32'(ord[u]), 32'd0);
         chk({tag, " mdata"}, omd[u], 32'd0);
         chk({tag, " misalign"}, 32'(omis[u]), 32'd0);
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_size = 2'd0;
      mem_unsigned = 1'b0; wb_res_mux = 2'd0; reg_write_enable = 1'b0; in_next_pc = '0;
      alu_res = '0; in_mem_addr = '0; in_mem_data = '0; in_immediate = '0; in_reg_dst = '0;
      foreach (mem_b[i]) mem_b[i] = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      chk("reset busy0", 32'(busy[0]), 32'd0);
      chk("reset busy3", 32'(busy[1]), 32'd0);
      @(negedge clk) rst = 1'b0;
      op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
      op(1, 0, 2'd2, 0, 32'h10, 32'h0);
      chk("lw dead", omd[1], 32'hDEADBEEF);
      op(0, 1, 2'd0, 0, 32'h13, 32'h00000080);
      op(1, 0, 2'd0, 0, 32'h13, 32'h0);
      chk("lb sign", omd[1], 32'hFFFFFF80);
      op(1, 0, 2'd0, 1, 32'h13, 32'h0);
      chk("lbu zero", omd[1], 32'h00000080);
      op(1, 0, 2'd2, 0, 32'h10, 32'h0);
      chk("lw merged", omd[1], 32'h80ADBEEF);
      op(0, 0, 2'd0, 0, 32'h0, 32'h0);
      op(0, 1, 2'd1, 0, 32'h11, 32'h00001234);
      op(1, 0, 2'd2, 0, 32'h10, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
      chk("sh trap keeps word", omd[1], 32'h80ADBEEF);
`else
      chk("sh masked lanes01", omd[1], 32'h80AD1234);
`endif
      op(0, 1, 2'd2, 0, 32'h0, 32'hCAFEF00D);
      op(1, 0, 2'd2, 0, 32'h1000, 32'h0);
      chk("wrap alias", omd[1], 32'hCAFEF00D);
      op(1, 1, 2'd2, 0, 32'h20, 32'h11223344);
      op(1, 0, 2'd1, 0, 32'h22, 32'h0);
      idle_cycle();
      // Abort a store: reset lands on the second wait cycle of the latency-3 stage.
      @(negedge clk);
      in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; mem_size = 2'd2;
      in_mem_addr = 32'h30; in_mem_data = 32'h55AA55AA; alu_res = 32'h1;
      @(posedge clk); @(posedge clk);
      @(negedge clk) rst = 1'b1;
      @(posedge clk); #1;
      chk_zero("abort");
      in_valid = 1'b0;
      #1;
      chk("abort busy3", 32'(busy[1]), 32'd0);
      foreach (mem_b[i]) mem_b[i] = 8'h00;
      @(negedge clk) rst = 1'b0;
      op(1, 0, 2'd2, 0, 32'h30, 32'h0);
      chk("abort no store", omd[1], 32'h0);
      op(0, 0, 2'd0, 0, 32'h0, 32'h0);
      for (int n = 0; n < 200; n++) begin
         logic [1:0] k;
         k = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) idle_cycle();
         op(k == 2'd1 || k == 2'd3, k == 2'd2 || (k == 2'd3 && $urandom_range(0, 3) == 0),
            2'($urandom_range(0, 2)), 1'($urandom),
            32'($urandom_range(0, 63)) | (32'($urandom_range(0, 3)) << 12), $urandom);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
